// File: rtl/pe_8ip_seq_ctrl.sv
// Job sequencer for the 8-lane PE_8IP dot-product datapath: IDLE -> DOT -> AGGR -> FLUSH.
// Drives the PE mux selects and ops from registers, latches the job format, and captures the result.
module pe_8ip_seq_ctrl #(
    parameter int DOT_CYCLES   = 15,
    parameter int AGGR_CYCLES  = 38,
    parameter int FLUSH_CYCLES = 15,
    parameter int CNT_W        = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_start,
    input  logic        io_abort,
    input  logic        io_use_int_in,
    input  logic [2:0]  io_rounding_in,
    input  logic [31:0] io_pe_out,
    output logic        io_ready,
    output logic        io_busy,
    output logic [1:0]  io_phase,
    output logic [19:0] io_m_sel,
    output logic [1:0]  io_addsub_0_op,
    output logic [1:0]  io_addsub_1_op,
    output logic        io_use_int,
    output logic [2:0]  io_rounding,
    output logic        io_tininess,
    output logic [31:0] io_result,
    output logic        io_result_valid
);

    typedef enum logic [1:0] {
        PH_IDLE  = 2'd0,
        PH_DOT   = 2'd1,
        PH_AGGR  = 2'd2,
        PH_FLUSH = 2'd3
    } phase_e;

    localparam logic [CNT_W-1:0] DOT_LAST   = CNT_W'(DOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] AGGR_LAST  = CNT_W'(AGGR_CYCLES - 1);
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYCLES - 1);

    // Select fields k=0..9, two bits each: IDLE/FLUSH forces the PE output to zero.
    localparam logic [19:0] M_SEL_ZERO = 20'hAFFFF;
    localparam logic [19:0] M_SEL_DOT  = 20'h50000;
    localparam logic [19:0] M_SEL_AGGR = 20'h0AA55;

    phase_e            phase_q, phase_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [19:0]       m_sel_q, m_sel_d;
    logic [1:0]        op_q, op_d;
    logic              use_int_q, use_int_d;
    logic [2:0]        rounding_q, rounding_d;
    logic [31:0]       result_q, result_d;
    logic              result_valid_q, result_valid_d;

    // Handshake: io_start is accepted on any rising edge where io_ready=1 (IDLE);
    // a start seen while busy is dropped, never queued. io_abort acts only in DOT/AGGR.
    always_comb begin
        phase_d        = phase_q;
        cnt_d          = cnt_q + 1'b1;
        use_int_d      = use_int_q;
        rounding_d     = rounding_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        case (phase_q)
            PH_IDLE: begin
                cnt_d = '0;
                if (io_start) begin
                    phase_d    = PH_DOT;
                    use_int_d  = io_use_int_in;
                    rounding_d = io_rounding_in;
                end
            end
            PH_DOT: begin
                if (io_abort) begin
                    phase_d = PH_FLUSH;
                    cnt_d   = '0;
                end else if (cnt_q == DOT_LAST) begin
                    phase_d = PH_AGGR;
                    cnt_d   = '0;
                end
            end
            PH_AGGR: begin
                if (io_abort) begin
                    phase_d = PH_FLUSH;
                    cnt_d   = '0;
                end else if (cnt_q == AGGR_LAST) begin
                    phase_d        = PH_FLUSH;
                    cnt_d          = '0;
                    result_d       = io_pe_out;
                    result_valid_d = 1'b1;
                end
            end
            default: begin
                if (cnt_q == FLUSH_LAST) begin
                    phase_d = PH_IDLE;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    // Selects are registered from the next phase so they always match io_phase.
    always_comb begin
        m_sel_d = M_SEL_ZERO;
        op_d    = 2'd0;
        case (phase_d)
            PH_DOT: begin
                m_sel_d = M_SEL_DOT;
                op_d    = 2'd1;
            end
            PH_AGGR: m_sel_d = M_SEL_AGGR;
            default: m_sel_d = M_SEL_ZERO;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            phase_q        <= PH_IDLE;
            cnt_q          <= '0;
            m_sel_q        <= M_SEL_ZERO;
            op_q           <= 2'd0;
            use_int_q      <= 1'b0;
            rounding_q     <= 3'd0;
            result_q       <= 32'd0;
            result_valid_q <= 1'b0;
        end else begin
            phase_q        <= phase_d;
            cnt_q          <= cnt_d;
            m_sel_q        <= m_sel_d;
            op_q           <= op_d;
            use_int_q      <= use_int_d;
            rounding_q     <= rounding_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign io_ready        = (phase_q == PH_IDLE);
    assign io_busy         = (phase_q != PH_IDLE);
    assign io_phase        = phase_q;
    assign io_m_sel        = m_sel_q;
    assign io_addsub_0_op  = op_q;
    assign io_addsub_1_op  = op_q;
    assign io_use_int      = use_int_q;
    assign io_rounding     = rounding_q;
    assign io_tininess     = 1'b1;
    assign io_result       = result_q;
    assign io_result_valid = result_valid_q;

endmodule

// File: tb/tb_pe_8ip_seq_ctrl.sv
// Bench for pe_8ip_seq_ctrl: directed jobs plus random start/abort/reset traffic,
// checked every cycle against a timeline model of the job schedule.
module tb_pe_8ip_seq_ctrl;
    localparam int D = 15;
    localparam int A = 38;
    localparam int F = 15;

    logic        clock = 1'b0;
    logic        reset;
    logic        io_start;
    logic        io_abort;
    logic        io_use_int_in;
    logic [2:0]  io_rounding_in;
    logic [31:0] io_pe_out;
    logic        io_ready;
    logic        io_busy;
    logic [1:0]  io_phase;
    logic [19:0] io_m_sel;
    logic [1:0]  io_addsub_0_op;
    logic [1:0]  io_addsub_1_op;
    logic        io_use_int;
    logic [2:0]  io_rounding;
    logic        io_tininess;
    logic [31:0] io_result;
    logic        io_result_valid;

    always #5 clock = ~clock;

    pe_8ip_seq_ctrl #(
        .DOT_CYCLES(D), .AGGR_CYCLES(A), .FLUSH_CYCLES(F), .CNT_W(8)
    ) dut (
        .clock(clock), .reset(reset), .io_start(io_start), .io_abort(io_abort),
        .io_use_int_in(io_use_int_in), .io_rounding_in(io_rounding_in), .io_pe_out(io_pe_out),
        .io_ready(io_ready), .io_busy(io_busy), .io_phase(io_phase), .io_m_sel(io_m_sel),
        .io_addsub_0_op(io_addsub_0_op), .io_addsub_1_op(io_addsub_1_op),
        .io_use_int(io_use_int), .io_rounding(io_rounding), .io_tininess(io_tininess),
        .io_result(io_result), .io_result_valid(io_result_valid)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Model: a job is a timeline; DOT covers [tdot, tdot+D), AGGR up to tflush, FLUSH [tflush, tflush+F).
    int          cyc = 0;
    bit          m_active = 0;
    int          m_tdot = 0;
    int          m_tflush = 0;
    logic [31:0] m_result = 0;
    bit          m_valid = 0;
    bit          m_use_int = 0;
    logic [2:0]  m_rnd = 0;
    int          accept_cyc = 0;
    int          valid_cyc = 0;
    int          valid_cnt, busy_cnt, ready_cnt;

    function automatic int model_phase(input int c);
        if (!m_active) return 0;
        if (c >= m_tflush) return 3;
        if (c < m_tdot + D) return 1;
        return 2;
    endfunction

    function automatic logic [19:0] exp_sel(input int p);
        if (p == 1) return 20'h50000;
        if (p == 2) return 20'h0AA55;
        return 20'hAFFFF;
    endfunction

    task automatic model_edge();
        int p;
        p = model_phase(cyc);
        if (!reset) begin
            m_active = 0; m_result = 0; m_valid = 0; m_use_int = 0; m_rnd = 0;
        end else begin
            m_valid = 0;
            case (p)
                0: if (io_start) begin
                    m_active  = 1;
                    m_tdot    = cyc + 1;
                    m_tflush  = cyc + 1 + D + A;
                    m_use_int = io_use_int_in;
                    m_rnd     = io_rounding_in;
                    accept_cyc = cyc + 1;
                end
                1, 2: if (io_abort) m_tflush = cyc + 1;
                      else if (p == 2 && cyc + 1 == m_tflush) begin
                          m_result = io_pe_out;
                          m_valid  = 1;
                      end
                default: if (cyc + 1 == m_tflush + F) m_active = 0;
            endcase
        end
        cyc++;
    endtask

    task automatic check_outputs();
        int p;
        p = model_phase(cyc);
        check("phase", 32'(io_phase), 32'(p));
        check("m_sel", 32'(io_m_sel), 32'(exp_sel(p)));
        check("op0", 32'(io_addsub_0_op), (p == 1) ? 32'd1 : 32'd0);
        check("op1", 32'(io_addsub_1_op), (p == 1) ? 32'd1 : 32'd0);
        check("ready", 32'(io_ready), 32'(p == 0));
        check("busy", 32'(io_busy), 32'(p != 0));
        check("result", io_result, m_result);
        check("valid", 32'(io_result_valid), 32'(m_valid));
        check("use_int", 32'(io_use_int), 32'(m_use_int));
        check("rounding", 32'(io_rounding), 32'(m_rnd));
        check("tininess", 32'(io_tininess), 32'd1);
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        @(negedge clock);
        check_outputs();
        if (io_result_valid) begin valid_cnt++; valid_cyc = cyc; end
        if (io_busy) busy_cnt++;
        if (io_ready) ready_cnt++;
    endtask

    task automatic clear_counts();
        valid_cnt = 0; busy_cnt = 0; ready_cnt = 0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            step();
            if (io_ready) break;
        end
        check("wait_idle", 32'(io_ready), 32'd1);
    endtask

    task automatic wait_phase(input logic [1:0] p);
        for (int i = 0; i < 200; i++) begin
            if (io_phase == p) break;
            step();
        end
        check("wait_phase", 32'(io_phase), 32'(p));
    endtask

    task automatic int_job(input string tag);
        clear_counts();
        io_start = 1; io_use_int_in = 1; io_rounding_in = 3'd7; io_pe_out = 32'h00001AD0;
        step();
        io_start = 0;
        wait_idle();
        check({tag, "_valid_cnt"}, 32'(valid_cnt), 32'd1);
        check({tag, "_latency"}, 32'(valid_cyc - accept_cyc), 32'd53);
        check({tag, "_busy_len"}, 32'(busy_cnt), 32'd68);
        check({tag, "_result"}, io_result, 32'h00001AD0);
    endtask

    initial begin
        int flush_len;
        reset = 0; io_start = 0; io_abort = 0; io_use_int_in = 0;
        io_rounding_in = 0; io_pe_out = 0;
        for (int i = 0; i < 3; i++) step();
        check("rst_result", io_result, 32'd0);
        check("rst_phase", 32'(io_phase), 32'd0);
        reset = 1;
        step();

        // INT job
        int_job("int");

        // FP job with ignored starts in DOT and FLUSH
        clear_counts();
        io_start = 1; io_use_int_in = 0; io_rounding_in = 3'd4; io_pe_out = 32'h45D68000;
        step();
        io_start = 0;
        for (int i = 0; i < 4; i++) step();
        io_start = 1; io_use_int_in = 1; io_rounding_in = 3'd2;
        step();
        io_start = 0;
        wait_phase(2'd3);
        io_start = 1;
        step();
        io_start = 0;
        wait_idle();
        check("fp_valid_cnt", 32'(valid_cnt), 32'd1);
        check("fp_result", io_result, 32'h45D68000);
        check("fp_use_int", 32'(io_use_int), 32'd0);
        check("fp_rounding", 32'(io_rounding), 32'd4);

        // Abort in the 10th AGGR cycle
        clear_counts();
        io_start = 1; io_pe_out = 32'h12345678;
        step();
        io_start = 0;
        wait_phase(2'd2);
        for (int i = 0; i < 9; i++) step();
        io_abort = 1;
        step();
        io_abort = 0;
        check("abort_to_flush", 32'(io_phase), 32'd3);
        flush_len = 0;
        for (int i = 0; i < 40; i++) begin
            if (io_ready) break;
            step();
            flush_len++;
        end
        check("abort_flush_len", 32'(flush_len), 32'd15);
        check("abort_no_valid", 32'(valid_cnt), 32'd0);
        check("abort_keep_result", io_result, 32'h45D68000);

        // Start together with abort in IDLE is accepted
        io_start = 1; io_abort = 1;
        step();
        io_start = 0; io_abort = 0;
        check("start_abort_idle", 32'(io_phase), 32'd1);

        // Reset mid-AGGR, then a clean INT job
        wait_phase(2'd2);
        for (int i = 0; i < 3; i++) step();
        reset = 0;
        step();
        reset = 1;
        check("midrst_phase", 32'(io_phase), 32'd0);
        check("midrst_result", io_result, 32'd0);
        check("midrst_valid", 32'(io_result_valid), 32'd0);
        int_job("int2");

        // Back-to-back jobs with start held high
        clear_counts();
        io_start = 1;
        for (int i = 0; i < 300; i++) begin
            step();
            if (valid_cnt == 2) break;
        end
        io_start = 0;
        check("b2b_valid_cnt", 32'(valid_cnt), 32'd2);
        check("b2b_idle_gap", 32'(ready_cnt), 32'd1);
        wait_idle();

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            io_start       = ($urandom_range(0, 9) == 0);
            io_abort       = ($urandom_range(0, 199) == 0);
            reset          = ($urandom_range(0, 499) != 0);
            io_use_int_in  = 1'($urandom_range(0, 1));
            io_rounding_in = 3'($urandom_range(0, 7));
            io_pe_out      = $urandom;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/pe_8ip_seq_ctrl.md
Name: pe_8ip_seq_ctrl

Overview:
Sequencer for the 8-lane PE_8IP dot-product datapath. It runs one job per start request. A job is a DOT phase (multiply and subtract), then an AGGR phase (reduction tree), then a FLUSH phase that zeroes the datapath. The block drives every PE mux select, the add/sub ops and the format/rounding controls, and captures the PE output as the job result. This replaces hand-timed select sequencing in benches and upper-level control.

Parameters:
DOT_CYCLES, 15, clock cycles held in DOT phase (legal range 1..2^CNT_W-1)
AGGR_CYCLES, 38, clock cycles held in AGGR phase (legal range 1..2^CNT_W-1)
FLUSH_CYCLES, 15, clock cycles held in FLUSH phase (legal range 1..2^CNT_W-1)
CNT_W, 8, phase counter width

Ports:
clock  in  1  single clock, all state updates on rising edge
reset  in  1  synchronous, active-low reset
io_start  in  1  job request; accepted only when io_ready=1
io_abort  in  1  abandon the current job; ignored in IDLE
io_use_int_in  in  1  job format: 1=INT32, 0=FP32; sampled with accepted start
io_rounding_in  in  3  rounding mode; sampled with accepted start
io_pe_out  in  32  PE io_out
io_ready  out  1  1 in IDLE only
io_busy  out  1  1 in DOT, AGGR or FLUSH
io_phase  out  2  current phase: 0=IDLE, 1=DOT, 2=AGGR, 3=FLUSH
io_m_sel  out  20  packed PE selects; field k occupies bits [2k+1:2k] and drives io_m_k_sel, k=0..9
io_addsub_0_op  out  2  PE addsub_0 op
io_addsub_1_op  out  2  PE addsub_1 op
io_use_int  out  1  latched format
io_rounding  out  3  latched rounding mode
io_tininess  out  1  constant 1
io_result  out  32  captured PE result; holds until the next capture
io_result_valid  out  1  one-cycle pulse when io_result updates

Behaviour:
- Reset (reset=0 at a rising edge):
  - phase=IDLE, counter=0.
  - io_result=0, io_result_valid=0, io_use_int=0, io_rounding=0.
  - Reset overrides start and abort. Reset mid-job returns to IDLE with no result pulse.
- Selects and ops are registered. They are a pure function of the current phase:
  - IDLE: m0..m7=3, m8/m9=2, addsub ops=0 (PE output forced to zero).
  - DOT: m0..m7=0, m8/m9=1, addsub ops=1.
  - AGGR: m0..m3=1, m4..m7=2, m8/m9=0, addsub ops=0.
  - FLUSH: same encoding as IDLE.
- IDLE -> DOT:
  - Taken on an edge with io_start=1.
  - io_use_int_in and io_rounding_in are latched on that same edge.
  - The first DOT cycle is the cycle after the accepting edge.
- DOT -> AGGR: after exactly DOT_CYCLES cycles in DOT.
- AGGR -> FLUSH:
  - After exactly AGGR_CYCLES cycles in AGGR.
  - On the leaving edge, io_result <= io_pe_out.
  - io_result_valid=1 during the first FLUSH cycle only.
- FLUSH -> IDLE: after exactly FLUSH_CYCLES cycles in FLUSH.
- Counter:
  - Loads 0 on every phase entry and increments once per cycle.
  - The phase ends when counter == PHASE_CYCLES-1. There is no wrap within a phase.
- Job length: start-accept edge to the io_result_valid cycle = DOT_CYCLES+AGGR_CYCLES cycles. io_ready returns FLUSH_CYCLES cycles later.
- io_start while busy is ignored and not queued. Inputs latched at start do not change mid-job.
- Abort:
  - io_abort in DOT or AGGR jumps to FLUSH on the next edge (counter=0), with no capture and no result_valid.
  - io_abort in FLUSH is ignored.
  - io_abort together with io_start in IDLE: start is accepted and abort ignored.
- Back-to-back jobs: a start held high is re-accepted on the first IDLE cycle. IDLE therefore lasts exactly 1 cycle between jobs.
- io_tininess is always 1. io_use_int and io_rounding remain at the last latched values while in IDLE.

Test Plan:
- INT job: io_use_int_in=1, io_rounding_in=7; PE lanes fed X0=23, Y0=11, X1=-55, Y1=-11 on all lanes → io_result=0x00001AD0 (6864) with a single io_result_valid pulse exactly 53 cycles after the accepting edge.
- FP job: io_use_int_in=0, io_rounding_in=4; same operands as FP32 (0x41B80000, 0x41300000, 0xC25C0000, 0xC1300000) → io_result=0x45D68000. Check io_use_int=0 and io_rounding=4 throughout the job.
- Phase trace: per-cycle check of io_phase and io_m_sel against the encoding table (DOT io_m_sel=0x50000; AGGR io_m_sel=0x0AA55; IDLE/FLUSH io_m_sel=0xAFFFF); io_busy=1 for exactly 68 cycles.
- Start pulsed in the 5th DOT cycle and again in FLUSH → ignored: one result, one valid pulse, and the latched format/rounding are unchanged.
- io_abort in the 10th AGGR cycle → FLUSH on the next edge; no result_valid; io_result keeps the previous job's value; io_ready returns after 15 cycles.
- reset=0 for one edge mid-AGGR → IDLE, io_result=0, io_result_valid=0. A following INT job completes with 0x00001AD0.
